// File: rtl/alu_mem_host.sv
// alu_mem_host: bus initiator that runs one ALU command through the register
// memory (write A, B, OP, EXEC; wait; read result; clear EXEC) and returns
// the result on a valid/ready response channel.
module alu_mem_host #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 3,
  parameter int unsigned RES_ADDR   = 4,
  parameter int unsigned EXEC_WAIT  = 2,
  parameter int unsigned RD_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [DATA_WIDTH-1:0] cmd_a,
  input  logic [DATA_WIDTH-1:0] cmd_b,
  input  logic [2:0]            cmd_op,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  busy,
  output logic                  enable,
  output logic                  rd_wr,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  input  logic [DATA_WIDTH-1:0] rd_data
);

  localparam int unsigned CNT_MAX = (EXEC_WAIT > RD_LATENCY) ? EXEC_WAIT : RD_LATENCY;
  localparam int unsigned CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'((EXEC_WAIT > 0) ? EXEC_WAIT - 1 : 0);
  localparam logic [CNT_W-1:0] RD_LAST   = CNT_W'((RD_LATENCY > 0) ? RD_LATENCY - 1 : 0);

  typedef enum logic [3:0] {
    IDLE,
    WR_A,
    WR_B,
    WR_OP,
    WR_EXEC,
    WAIT,
    RD_REQ,
    RD_WAIT,
    CLR_EXEC,
    RSP
  } state_t;

  state_t                state, state_next;
  logic [CNT_W-1:0]      cnt;
  logic [DATA_WIDTH-1:0] b_q;
  logic [2:0]            op_q;

  logic                  enable_d;
  logic                  rd_wr_d;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic [DATA_WIDTH-1:0] wr_data_d;

  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);

  // Next-state transitions, then bus values decoded from the state being entered
  // so the bus registers line up with the state register.
  always_comb begin
    state_next = state;
    enable_d   = 1'b0;
    rd_wr_d    = 1'b1;
    addr_d     = '0;
    wr_data_d  = '0;

    case (state)
      IDLE:     if (cmd_valid) state_next = WR_A;
      WR_A:     state_next = WR_B;
      WR_B:     state_next = WR_OP;
      WR_OP:    state_next = WR_EXEC;
      WR_EXEC:  state_next = (EXEC_WAIT == 0) ? RD_REQ : WAIT;
      WAIT:     if (cnt == WAIT_LAST) state_next = RD_REQ;
      RD_REQ:   state_next = RD_WAIT;
      RD_WAIT:  if (cnt == RD_LAST) state_next = CLR_EXEC;
      CLR_EXEC: state_next = RSP;
      RSP:      if (rsp_ready) state_next = IDLE;
      default:  state_next = IDLE;
    endcase

    case (state_next)
      // WR_A is only entered on the accept edge, so A comes straight from the
      // command port rather than from a latched copy.
      WR_A: begin
        enable_d  = 1'b1;
        rd_wr_d   = 1'b0;
        addr_d    = ADDR_WIDTH'(0);
        wr_data_d = cmd_a;
      end
      WR_B: begin
        enable_d  = 1'b1;
        rd_wr_d   = 1'b0;
        addr_d    = ADDR_WIDTH'(1);
        wr_data_d = b_q;
      end
      WR_OP: begin
        enable_d  = 1'b1;
        rd_wr_d   = 1'b0;
        addr_d    = ADDR_WIDTH'(2);
        wr_data_d[DATA_WIDTH-1 -: 3] = op_q;
      end
      WR_EXEC: begin
        enable_d  = 1'b1;
        rd_wr_d   = 1'b0;
        addr_d    = ADDR_WIDTH'(3);
        wr_data_d[DATA_WIDTH-1] = 1'b1;
      end
      RD_REQ: begin
        enable_d  = 1'b1;
        rd_wr_d   = 1'b1;
        addr_d    = ADDR_WIDTH'(RES_ADDR);
      end
      CLR_EXEC: begin
        enable_d  = 1'b1;
        rd_wr_d   = 1'b0;
        addr_d    = ADDR_WIDTH'(3);
      end
      default: ;
    endcase
  end

  // State, wait counter, latched operands, registered bus and response.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      b_q       <= '0;
      op_q      <= '0;
      enable    <= 1'b0;
      rd_wr     <= 1'b1;
      addr      <= '0;
      wr_data   <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
    end else begin
      state     <= state_next;
      enable    <= enable_d;
      rd_wr     <= rd_wr_d;
      addr      <= addr_d;
      wr_data   <= wr_data_d;
      rsp_valid <= (state_next == RSP);

      if (state_next != state)
        cnt <= '0;
      else if (state == WAIT || state == RD_WAIT)
        cnt <= cnt + 1'b1;

      if (state == IDLE && cmd_valid) begin
        b_q  <= cmd_b;
        op_q <= cmd_op;
      end

      if (state == RD_WAIT && cnt == RD_LAST)
        rsp_data <= rd_data;
    end
  end

endmodule

// File: tb/tb_alu_mem_host.sv
// Directed bench for alu_mem_host: default build plus an EXEC_WAIT=0 /
// RD_LATENCY=1 build, with a scripted memory read-data driver.
module tb_alu_mem_host;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       cmd_valid = 1'b0, cmd_valid2 = 1'b0;
  logic [7:0] cmd_a = '0, cmd_b = '0;
  logic [2:0] cmd_op = '0;
  logic       rsp_ready = 1'b1;
  logic [7:0] rd_data = '0, rd_data2 = '0;

  logic       cmd_ready, rsp_valid, busy, enable, rd_wr;
  logic [7:0] rsp_data, wr_data;
  logic [2:0] addr;
  logic       cmd_ready2, rsp_valid2, busy2, enable2, rd_wr2;
  logic [7:0] rsp_data2, wr_data2;
  logic [2:0] addr2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_mem_host u_dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .busy(busy),
    .enable(enable), .rd_wr(rd_wr), .addr(addr), .wr_data(wr_data), .rd_data(rd_data)
  );

  alu_mem_host #(.EXEC_WAIT(0), .RD_LATENCY(1)) u_dut2 (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid2), .cmd_ready(cmd_ready2),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
    .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready), .rsp_data(rsp_data2), .busy(busy2),
    .enable(enable2), .rd_wr(rd_wr2), .addr(addr2), .wr_data(wr_data2), .rd_data(rd_data2)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Expected {enable, rd_wr, addr, wr_data} in cycle k after the accept edge.
  function automatic logic [12:0] bus_exp(input int k, input logic [7:0] a, input logic [7:0] b,
                                          input logic [2:0] op, input int w, input int l);
    if (k == 1)         return {2'b10, 3'd0, a};
    if (k == 2)         return {2'b10, 3'd1, b};
    if (k == 3)         return {2'b10, 3'd2, op, 5'b00000};
    if (k == 4)         return {2'b10, 3'd3, 8'h80};
    if (k == 5 + w)     return {2'b11, 3'd4, 8'h00};
    if (k == 6 + w + l) return {2'b10, 3'd3, 8'h00};
    return {2'b01, 3'd0, 8'h00};
  endfunction

  // Called one step after the accept edge; runs through the response handshake
  // and checks the following IDLE cycle.
  task automatic run_cmd(input bit sel, input logic [7:0] a, input logic [7:0] b,
                         input logic [2:0] op, input logic [7:0] res,
                         input int w, input int l, input int stall);
    int last;
    logic [12:0] bus;
    last = 7 + w + l;
    rsp_ready = (stall == 0);
    for (int k = 1; k <= last; k++) begin
      if (sel) rd_data2 = (k == 5 + w + l) ? res : 8'hEE;
      else     rd_data  = (k == 5 + w + l) ? res : 8'hEE;
      bus = sel ? {enable2, rd_wr2, addr2, wr_data2} : {enable, rd_wr, addr, wr_data};
      check($sformatf("bus[%0d] cyc%0d", sel, k), {3'b0, bus}, {3'b0, bus_exp(k, a, b, op, w, l)});
      check($sformatf("rsp_valid[%0d] cyc%0d", sel, k), {15'b0, sel ? rsp_valid2 : rsp_valid},
            {15'b0, k == last});
      check($sformatf("busy/ready[%0d] cyc%0d", sel, k),
            {14'b0, sel ? {busy2, cmd_ready2} : {busy, cmd_ready}}, 16'h0002);
      if (k == last)
        check($sformatf("rsp_data[%0d]", sel), {8'b0, sel ? rsp_data2 : rsp_data}, {8'b0, res});
      if (k < last) step();
    end
    for (int s = 0; s < stall; s++) begin
      step();
      check($sformatf("stall[%0d] %0d", s, sel),
            {8'b0, rsp_data, 5'b0, rsp_valid, enable, cmd_ready}, {8'b0, res, 8'b00000100});
    end
    rsp_ready = 1'b1;
    step();
    check($sformatf("post-hs[%0d]", sel),
          {12'b0, sel ? {rsp_valid2, cmd_ready2, busy2, enable2} : {rsp_valid, cmd_ready, busy, enable}},
          16'h0004);
  endtask

  initial begin
    step();
    step();
    reset = 1'b1;
    check("reset bus", {3'b0, enable, rd_wr, addr, wr_data}, 16'h0800);
    check("reset rsp", {6'b0, rsp_valid, busy, rsp_data}, 16'h0000);
    check("reset ready", {14'b0, cmd_ready, cmd_ready2}, 16'h0003);

    // Single command; operands changed right after acceptance.
    cmd_a = 8'h12; cmd_b = 8'h34; cmd_op = 3'b101; cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0; cmd_a = 8'hFF; cmd_b = 8'hFF; cmd_op = 3'b111;
    run_cmd(1'b0, 8'h12, 8'h34, 3'b101, 8'h46, 2, 2, 0);

    // Response stall of 5 cycles.
    cmd_a = 8'h77; cmd_b = 8'h01; cmd_op = 3'b011; cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    run_cmd(1'b0, 8'h77, 8'h01, 3'b011, 8'h78, 2, 2, 5);

    // Back-to-back: cmd_valid stays high, second operands offered during the first.
    cmd_a = 8'h21; cmd_b = 8'h03; cmd_op = 3'b000; cmd_valid = 1'b1;
    step();
    cmd_a = 8'h0A; cmd_b = 8'h05; cmd_op = 3'b010;
    run_cmd(1'b0, 8'h21, 8'h03, 3'b000, 8'h24, 2, 2, 0);
    step();
    cmd_valid = 1'b0;
    run_cmd(1'b0, 8'h0A, 8'h05, 3'b010, 8'h0F, 2, 2, 0);

    // Short build: EXEC_WAIT=0, RD_LATENCY=1.
    cmd_a = 8'h0F; cmd_b = 8'h01; cmd_op = 3'b001; cmd_valid2 = 1'b1;
    step();
    cmd_valid2 = 1'b0;
    run_cmd(1'b1, 8'h0F, 8'h01, 3'b001, 8'h10, 0, 1, 0);

    // Reset during WAIT: command dropped, no EXEC clear afterwards.
    cmd_a = 8'h55; cmd_b = 8'h66; cmd_op = 3'b100; cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    repeat (5) step();
    check("in WAIT", {13'b0, busy, enable, cmd_ready}, 16'h0004);
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
    check("midreset bus", {3'b0, enable, rd_wr, addr, wr_data}, 16'h0800);
    check("midreset rsp", {5'b0, rsp_valid, busy, cmd_ready, rsp_data}, 16'h0100);
    for (int i = 0; i < 8; i++) begin
      step();
      check($sformatf("no CLR_EXEC %0d", i), {14'b0, enable, busy}, 16'h0000);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
